// File: rtl/load_store_unit.sv
// Data-side load/store unit: runs one access on a wait-request memory bus,
// steering store bytes onto lanes and extracting / extending / merging load data.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        fault,
  output logic        stall,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  output logic [3:0]  data_byteenable,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata
);

  localparam logic [2:0] OP_B  = 3'b000, OP_H  = 3'b001, OP_W  = 3'b010, OP_WL = 3'b011,
                         OP_BU = 3'b100, OP_HU = 3'b101, OP_WR = 3'b110, OP_RSV = 3'b111;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [2:0]  op_q;
  logic [1:0]  k_q;
  logic [31:0] rt_q;

  logic        illegal_d;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;
  logic [31:0] ld_d;

  assign stall = req & ~done;

  always_comb begin
    illegal_d = 1'b0;
    if (op == OP_RSV) illegal_d = 1'b1;
    if ((op == OP_H || op == OP_HU) && addr[0]) illegal_d = 1'b1;
    if (op == OP_W && addr[1:0] != 2'b00) illegal_d = 1'b1;
    if (is_store && !(op == OP_B || op == OP_H || op == OP_W)) illegal_d = 1'b1;
  end

  // Store lane steering; loads request the full word and drive no data.
  always_comb begin
    wdata_d = 32'h0;
    be_d    = 4'b1111;
    if (is_store) begin
      case (op)
        OP_B: begin
          wdata_d = {4{rt_data[7:0]}};
          be_d    = 4'b0001 << addr[1:0];
        end
        OP_H: begin
          wdata_d = {2{rt_data[15:0]}};
          be_d    = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = rt_data;
          be_d    = 4'b1111;
        end
      endcase
    end
  end

  logic [4:0]  sh8;
  logic [31:0] m_shr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Load extraction from the live bus word, using the registered request.
  always_comb begin
    sh8    = {k_q, 3'b000};
    m_shr  = data_readdata >> sh8;
    byte_v = m_shr[7:0];
    half_v = k_q[1] ? data_readdata[31:16] : data_readdata[15:0];
    case (op_q)
      OP_B:    ld_d = {{24{byte_v[7]}}, byte_v};
      OP_BU:   ld_d = {24'h0, byte_v};
      OP_H:    ld_d = {{16{half_v[15]}}, half_v};
      OP_HU:   ld_d = {16'h0, half_v};
      // Mask shifts are pre-biased so k=3 yields an all-zero mask without a 32-bit shift.
      OP_WL:   ld_d = (data_readdata << {~k_q, 3'b000}) | (rt_q & (32'h00FF_FFFF >> sh8));
      OP_WR:   ld_d = m_shr | (rt_q & ~(32'hFFFF_FFFF >> sh8));
      default: ld_d = data_readdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      is_store_q      <= 1'b0;
      op_q            <= 3'b000;
      k_q             <= 2'b00;
      rt_q            <= 32'h0;
      load_data       <= 32'h0;
      done            <= 1'b0;
      fault           <= 1'b0;
      data_read       <= 1'b0;
      data_write      <= 1'b0;
      data_address    <= 32'h0;
      data_writedata  <= 32'h0;
      data_byteenable <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          if (req) begin
            is_store_q <= is_store;
            op_q       <= op;
            k_q        <= addr[1:0];
            rt_q       <= rt_data;
            if (illegal_d) begin
              state_q <= RESP;
              done    <= 1'b1;
              fault   <= 1'b1;
            end else begin
              state_q         <= BUS;
              data_read       <= ~is_store;
              data_write      <= is_store;
              data_address    <= {addr[31:2], 2'b00};
              data_writedata  <= wdata_d;
              data_byteenable <= be_d;
            end
          end
        end
        BUS: begin
          if (!data_waitrequest) begin
            data_read  <= 1'b0;
            data_write <= 1'b0;
            if (!is_store_q) load_data <= ld_d;
            done    <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          done    <= 1'b0;
          fault   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboarded load results, per-cycle bus
// checks, fault path and reset in the middle of a bus transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, is_store;
  logic [2:0]  op;
  logic [31:0] addr, rt_data;
  logic [31:0] load_data;
  logic        done, fault, stall;
  logic [31:0] data_address;
  logic        data_read, data_write;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic        data_waitrequest;
  logic [31:0] data_readdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = 32'h0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .is_store(is_store), .op(op),
    .addr(addr), .rt_data(rt_data), .load_data(load_data), .done(done),
    .fault(fault), .stall(stall), .data_address(data_address),
    .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_waitrequest(data_waitrequest), .data_readdata(data_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input string nm, input logic st, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] rt, input logic [31:0] word,
                        input int waits, input logic flt, input logic [31:0] exp_ld,
                        input logic [31:0] exp_wd, input logic [3:0] exp_be);
    int rem, nstb, dcyc;
    logic [31:0] e;
    @(posedge clk); #1;
    req = 1'b1; is_store = st; op = o; addr = a; rt_data = rt;
    data_readdata = word; data_waitrequest = (waits > 0);
    rem = waits; nstb = 0; dcyc = -1;
    if (flt || st) exp_q.push_back(last_ld);
    else begin
      exp_q.push_back(exp_ld);
      last_ld = exp_ld;
    end
    for (int c = 0; c < 40 && dcyc < 0; c++) begin
      @(negedge clk);
      chk({nm, " stall"}, {31'h0, stall}, {31'h0, ~done});
      if (c == 0) chk({nm, " no strobe c0"}, {30'h0, data_read, data_write}, 32'h0);
      if (data_read || data_write) begin
        nstb++;
        chk({nm, " strobe"}, {30'h0, data_read, data_write}, {30'h0, ~st, st});
        chk({nm, " address"}, data_address, {a[31:2], 2'b00});
        chk({nm, " writedata"}, data_writedata, exp_wd);
        chk({nm, " byteenable"}, {28'h0, data_byteenable}, {28'h0, exp_be});
        data_waitrequest = (rem > 0);
        if (rem > 0) rem--;
      end
      if (done) begin
        dcyc = c;
        chk({nm, " fault"}, {31'h0, fault}, {31'h0, flt});
        if (exp_q.size() == 0) chk({nm, " scoreboard empty"}, 32'h1, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk({nm, " load_data"}, load_data, e);
        end
      end
    end
    chk({nm, " done cycle"}, 32'(dcyc), flt ? 32'd1 : 32'(2 + waits));
    chk({nm, " strobe cycles"}, 32'(nstb), flt ? 32'd0 : 32'(waits + 1));
    @(posedge clk); #1;
    req = 1'b0; data_waitrequest = 1'b0;
    @(negedge clk);
    chk({nm, " done pulse width"}, {30'h0, done, fault}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; is_store = 1'b0; op = 3'b000; addr = 32'h0;
    rt_data = 32'h0; data_waitrequest = 1'b0; data_readdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset load_data", load_data, 32'h0);
    chk("reset flags", {28'h0, done, fault, data_read, data_write}, 32'h0);
    chk("reset address", data_address, 32'h0);
    chk("reset writedata", data_writedata, 32'h0);
    chk("reset byteenable", {28'h0, data_byteenable}, 32'h0);
    reset = 1'b0;

    //      name    st    op      addr          rt            word         w  flt   exp_ld        exp_wd        be
    access("LW",   1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 32'h0,        4'b1111);
    access("LB",   1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80123456, 0, 1'b0, 32'hFFFFFF80, 32'h0,        4'b1111);
    access("LBU",  1'b0, 3'b100, 32'h0000_1003, 32'h0,        32'h80123456, 0, 1'b0, 32'h00000080, 32'h0,        4'b1111);
    access("LH",   1'b0, 3'b001, 32'h0000_1002, 32'h0,        32'h80123456, 0, 1'b0, 32'hFFFF8012, 32'h0,        4'b1111);
    access("LHU",  1'b0, 3'b101, 32'h0000_1002, 32'h0,        32'h80123456, 0, 1'b0, 32'h00008012, 32'h0,        4'b1111);
    access("LHU0", 1'b0, 3'b101, 32'h0000_1000, 32'h0,        32'h80123456, 1, 1'b0, 32'h00003456, 32'h0,        4'b1111);
    access("SB",   1'b1, 3'b000, 32'h0000_2001, 32'h000000AB, 32'h0,        0, 1'b0, 32'h0,        32'hABABABAB, 4'b0010);
    access("SH",   1'b1, 3'b001, 32'h0000_2002, 32'h00001234, 32'h0,        0, 1'b0, 32'h0,        32'h12341234, 4'b1100);
    access("LWL",  1'b0, 3'b011, 32'h0000_1001, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, 32'hCCDD3344, 32'h0,        4'b1111);
    access("LWR",  1'b0, 3'b110, 32'h0000_1001, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, 32'h11AABBCC, 32'h0,        4'b1111);
    access("LWL3", 1'b0, 3'b011, 32'h0000_1003, 32'h11223344, 32'hAABBCCDD, 0, 1'b0, 32'hAABBCCDD, 32'h0,        4'b1111);
    access("SW",   1'b1, 3'b010, 32'h0000_3000, 32'hCAFEF00D, 32'h0,        3, 1'b0, 32'h0,        32'hCAFEF00D, 4'b1111);
    access("LWmis",1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h12345678, 0, 1'b1, 32'h0,        32'h0,        4'b0000);
    access("SBU",  1'b1, 3'b100, 32'h0000_2000, 32'h000000FF, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000);
    access("LHmis",1'b0, 3'b101, 32'h0000_1001, 32'h0,        32'h12345678, 0, 1'b1, 32'h0,        32'h0,        4'b0000);
    access("RSV",  1'b0, 3'b111, 32'h0000_1000, 32'h0,        32'h12345678, 0, 1'b1, 32'h0,        32'h0,        4'b0000);

    // Reset while the bus is stalled on waitrequest.
    @(posedge clk); #1;
    req = 1'b1; is_store = 1'b0; op = 3'b010; addr = 32'h0000_4000;
    data_waitrequest = 1'b1; data_readdata = 32'h55AA55AA;
    @(negedge clk);
    @(negedge clk);
    chk("rst setup read", {31'h0, data_read}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst read drop", {31'h0, data_read}, 32'h0);
    chk("rst load_data", load_data, 32'h0);
    chk("rst address", data_address, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no done", {31'h0, done}, 32'h0);
    end
    req = 1'b0; data_waitrequest = 1'b0;
    reset = 1'b0;
    last_ld = 32'h0;
    access("LWpost", 1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h01020304, 0, 1'b0, 32'h01020304, 32'h0, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
